// File: rtl/norm_result_fifo.sv
// Result FIFO downstream of the running-L2-norm block; drops and counts when full.
// Define NORM_PEAK_EN to add the peak tracker (peak output, peak_clr input).
module norm_result_fifo #(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 8,
  parameter  int CNT_W = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] g_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] drop_cnt,
`ifdef NORM_PEAK_EN
  input  logic             peak_clr,
  output logic [WIDTH-1:0] peak,
`endif
  output logic             overflow
);

  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             ovf_q, ovf_d;
  logic             pop, push, drop;

  assign empty      = (count_q == '0);
  assign full       = (count_q == FULL_C);
  assign dout_valid = !empty;
  assign dout       = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign drop_cnt   = drop_q;
  assign overflow   = ovf_q;

  // A pop frees a slot, so a full FIFO still accepts a word on the same edge.
  assign pop  = dout_valid & dout_ready;
  assign push = valid_in & (!full | pop);
  assign drop = valid_in & full & !pop;

  // Next-state for pointers, occupancy and drop bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
    end
  end

  // Control state and storage; reset discards all contents.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
      if (push) mem_q[wr_ptr_q] <= g_in;
    end
  end

`ifdef NORM_PEAK_EN
  logic [WIDTH-1:0] peak_q, peak_d;

  assign peak = peak_q;

  // Max of accepted words; a clear on a push edge restarts from that word.
  always_comb begin
    peak_d = peak_q;
    if (peak_clr)                  peak_d = push ? g_in : '0;
    else if (push && g_in > peak_q) peak_d = g_in;
  end

  // Peak register.
  always_ff @(posedge clk) begin
    if (!reset) peak_q <= '0;
    else        peak_q <= peak_d;
  end
`endif

endmodule

// File: tb/tb_norm_result_fifo.sv
// Directed bench for norm_result_fifo with a queue scoreboard.
// Peak checks are built when NORM_PEAK_EN is defined.
module tb_norm_result_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] g_in = '0;
  logic       valid_in = 1'b0;
  logic       dout_ready = 1'b0;
  logic [9:0] dout;
  logic       dout_valid;
  logic [3:0] count;
  logic       full, empty;
  logic [7:0] drop_cnt;
  logic       overflow;
`ifdef NORM_PEAK_EN
  logic       peak_clr = 1'b0;
  logic [9:0] peak;
`endif

  int         checks = 0;
  int         errors = 0;
  logic [9:0] mq[$];
  int         mdrop = 0;
  bit         movf = 1'b0;
  logic [9:0] mpeak = '0;
  string      tag = "";

  norm_result_fifo #(.WIDTH(10), .DEPTH(8), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .g_in       (g_in),
    .valid_in   (valid_in),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .drop_cnt   (drop_cnt),
`ifdef NORM_PEAK_EN
    .peak_clr   (peak_clr),
    .peak       (peak),
`endif
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, nm, obs, exp);
    end
  endtask

  task automatic state_chk();
    chk("count", 32'(count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == 8));
    chk("dout_valid", 32'(dout_valid), 32'(mq.size() != 0));
    chk("drop_cnt", 32'(drop_cnt), 32'(mdrop));
    chk("overflow", 32'(overflow), 32'(movf));
    if (mq.size() != 0) chk("head", 32'(dout), 32'(mq[0]));
`ifdef NORM_PEAK_EN
    chk("peak", 32'(peak), 32'(mpeak));
`endif
  endtask

  // One clock: drive at negedge, predict, check state at the next negedge.
  task automatic cycle(input bit v, input logic [9:0] g, input bit rdy,
                       input bit clr);
    bit mpop, mpush;
    valid_in   = v;
    g_in       = g;
    dout_ready = rdy;
`ifdef NORM_PEAK_EN
    peak_clr   = clr;
`endif
    mpop  = (mq.size() != 0) && rdy;
    mpush = v && ((mq.size() < 8) || mpop);
    if (mpop) begin
      chk("pop", 32'(dout), 32'(mq[0]));
      void'(mq.pop_front());
    end
    if (mpush) mq.push_back(g);
    if (v && !mpush) begin
      if (mdrop < 255) mdrop++;
      movf = 1'b1;
    end
    if (clr)                      mpeak = mpush ? g : 10'd0;
    else if (mpush && g > mpeak)  mpeak = g;
    @(posedge clk);
    @(negedge clk);
    valid_in   = 1'b0;
    dout_ready = 1'b0;
`ifdef NORM_PEAK_EN
    peak_clr   = 1'b0;
`endif
    state_chk();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    mq.delete();
    mdrop = 0;
    movf  = 1'b0;
    mpeak = '0;
    state_chk();
    chk("dout_rst", 32'(dout), 32'd0);
  endtask

  initial begin
    @(negedge clk);

    tag = "reset";
    do_reset(2);
    cycle(1'b0, 10'd0, 1'b1, 1'b0);

    tag = "basic";
    cycle(1'b1, 10'd21, 1'b0, 1'b0);
    cycle(1'b1, 10'd41, 1'b0, 1'b0);
    cycle(1'b1, 10'd76, 1'b0, 1'b0);
    chk("count3", 32'(count), 32'd3);
    cycle(1'b0, 10'd0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 10'd0, 1'b1, 1'b0);
    chk("empty_end", 32'(empty), 32'd1);

    tag = "empty_pushpop";
    cycle(1'b1, 10'd333, 1'b1, 1'b0);
    chk("count1", 32'(count), 32'd1);
    cycle(1'b0, 10'd0, 1'b1, 1'b0);

    tag = "fill";
    for (int i = 1; i <= 9; i++) cycle(1'b1, 10'(i), 1'b0, 1'b0);
    chk("drop1", 32'(drop_cnt), 32'd1);
    chk("ovf1", 32'(overflow), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      chk("drain", 32'(dout), 32'(i));
      cycle(1'b0, 10'd0, 1'b1, 1'b0);
    end

    tag = "full_pushpop";
    for (int i = 11; i <= 18; i++) cycle(1'b1, 10'(i), 1'b0, 1'b0);
    chk("full8", 32'(full), 32'd1);
    cycle(1'b1, 10'd100, 1'b1, 1'b0);
    chk("count8", 32'(count), 32'd8);
    chk("drop_same", 32'(drop_cnt), 32'd1);
    repeat (8) cycle(1'b0, 10'd0, 1'b1, 1'b0);

    tag = "saturate";
    for (int i = 0; i < 8; i++) cycle(1'b1, 10'(500 + i), 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) cycle(1'b1, 10'(900), 1'b0, 1'b0);
    chk("drop_sat", 32'(drop_cnt), 32'd255);
    cycle(1'b0, 10'd0, 1'b1, 1'b0);
    cycle(1'b1, 10'd1023, 1'b0, 1'b0);

    tag = "mid_reset";
    do_reset(1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 10'(200 + i), 1'b0, 1'b0);
    do_reset(1);
    chk("ovf_clr", 32'(overflow), 32'd0);
    cycle(1'b1, 10'd7, 1'b0, 1'b0);
    chk("rd7", 32'(dout), 32'd7);
    cycle(1'b0, 10'd0, 1'b1, 1'b0);

`ifdef NORM_PEAK_EN
    tag = "peak";
    do_reset(1);
    cycle(1'b1, 10'd21, 1'b0, 1'b0);
    cycle(1'b1, 10'd76, 1'b0, 1'b0);
    cycle(1'b1, 10'd41, 1'b0, 1'b0);
    chk("peak76", 32'(peak), 32'd76);
    cycle(1'b1, 10'd5, 1'b0, 1'b1);
    chk("peak5", 32'(peak), 32'd5);
    cycle(1'b0, 10'd0, 1'b0, 1'b1);
    chk("peak0", 32'(peak), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
